cache_rd_arbiter: RTL and testbench

CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_rd_arbiter.sv | 140 ++++++++++++++
 tb/tb_cache_rd_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Purpose : Shared read-type codes, arbiter FSM state encoding and requester
//           (owner) encoding for the cache read arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_rd_arbiter
// Purpose : Arbitrates ICache line refills and DCache reads onto a single
//           memory read port, one outstanding transaction at a time, with
//           round-robin on contention and return-beat routing to the owner.
// Ports   : clk, resetn           - clock, async active-low reset
//           ic_rd_req/addr/rdy    - ICache request (always a line refill)
//           ic_ret_valid          - return beat for ICache
//           dc_rd_req/type/addr/rdy - DCache request (word or line)
//           dc_ret_valid          - return beat for DCache
//           ret_last, ret_data    - shared return last flag / data
//           mem_rd_req/type/addr/rdy - memory-side request handshake
//           mem_ret_valid/last/data - memory-side return beats
//           proto_err             - sticky protocol-error flag
// Revision: 1.0 - initial release
// ============================================================================
module cache_rd_arbiter
  import cache_pkg::*;
#(
  parameter int BYTES_PER_LINE = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ic_rd_req,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  input  logic        dc_rd_req,
  input  logic [2:0]  dc_rd_type,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_rdy,
  output logic        dc_ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  output logic        mem_rd_req,
  output logic [2:0]  mem_rd_type,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic        mem_ret_valid,
  input  logic        mem_ret_last,
  input  logic [31:0] mem_ret_data,
  output logic        proto_err
);

  localparam int LINE_BEATS = BYTES_PER_LINE / 4;
  localparam int CNT_W      = $clog2(LINE_BEATS) + 1;

  state_t           state_q, state_d;
  owner_t           owner_q;
  owner_t           last_grant_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] last_idx;
  logic             grant_ic;
  logic             grant_dc;
  logic             in_resp;

  assign in_resp = (state_q == ST_RESP);

  // Grant decision. Depends only on request inputs and local state, so there
  // is no path from mem_rd_rdy into the rdy outputs. Gated by resetn so the
  // rdy outputs are quiet while reset is held.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (resetn && state_q == ST_IDLE) begin
      if (ic_rd_req && dc_rd_req) begin
        // Whoever was not granted last wins the tie.
        if (last_grant_q == OWN_IC) grant_dc = 1'b1;
        else                        grant_ic = 1'b1;
      end else if (ic_rd_req) begin
        grant_ic = 1'b1;
      end else if (dc_rd_req) begin
        grant_dc = 1'b1;
      end
    end
  end

  assign ic_rd_rdy = grant_ic;
  assign dc_rd_rdy = grant_dc;

  // Return path: zero-latency pass-through, steered by the latched owner.
  assign ic_ret_valid = resetn && in_resp && mem_ret_valid && (owner_q == OWN_IC);
  assign dc_ret_valid = resetn && in_resp && mem_ret_valid && (owner_q == OWN_DC);
  assign ret_last     = in_resp && mem_ret_last;
  assign ret_data     = in_resp ? mem_ret_data : 32'h0;

  // Index of the beat that should carry the last flag for the current type.
  assign last_idx = (mem_rd_type == RD_TYPE_LINE) ? CNT_W'(LINE_BEATS - 1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_ic || grant_dc)          state_d = ST_REQ;
      ST_REQ:  if (mem_rd_req && mem_rd_rdy)      state_d = ST_RESP;
      ST_RESP: if (mem_ret_valid && mem_ret_last) state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IC;
      last_grant_q <= OWN_IC;
      beat_cnt_q   <= '0;
      proto_err    <= 1'b0;
      mem_rd_req   <= 1'b0;
      mem_rd_addr  <= 32'h0;
      mem_rd_type  <= 3'b000;
    end else begin
      state_q <= state_d;

      if (grant_ic || grant_dc) begin
        owner_q      <= grant_dc ? OWN_DC : OWN_IC;
        last_grant_q <= grant_dc ? OWN_DC : OWN_IC;
        mem_rd_req   <= 1'b1;
        mem_rd_addr  <= grant_dc ? dc_rd_addr : ic_rd_addr;
        mem_rd_type  <= grant_dc ? dc_rd_type : RD_TYPE_LINE;
        beat_cnt_q   <= '0;
      end else if (state_q == ST_REQ && mem_rd_rdy) begin
        mem_rd_req <= 1'b0;
      end

      if (in_resp && mem_ret_valid) begin
        if (mem_ret_last) begin
          beat_cnt_q <= '0;
          if (beat_cnt_q != last_idx) proto_err <= 1'b1;
        end else begin
          beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
      end

      // Any return beat outside RESP is a memory-side protocol violation.
      if (!in_resp && mem_ret_valid) proto_err <= 1'b1;
    end
  end

endmodule : cache_rd_arbiter
`default_nettype wire

// File: tb/tb_cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_rd_arbiter
// Purpose : Directed self-checking bench for cache_rd_arbiter.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_rd_arbiter;

  logic        clk;
  logic        resetn;
  logic        ic_rd_req;
  logic [31:0] ic_rd_addr;
  logic        ic_rd_rdy;
  logic        ic_ret_valid;
  logic        dc_rd_req;
  logic [2:0]  dc_rd_type;
  logic [31:0] dc_rd_addr;
  logic        dc_rd_rdy;
  logic        dc_ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic        mem_rd_req;
  logic [2:0]  mem_rd_type;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_rdy;
  logic        mem_ret_valid;
  logic        mem_ret_last;
  logic [31:0] mem_ret_data;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IC_A0 = 32'h1fc0_0000;
  localparam logic [31:0] IC_A1 = 32'h1fc0_0040;
  localparam logic [31:0] DC_A0 = 32'h8000_1004;
  localparam logic [31:0] DC_A1 = 32'h8000_2000;

  cache_rd_arbiter #(.BYTES_PER_LINE(64)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ic_rd_req    (ic_rd_req),
    .ic_rd_addr   (ic_rd_addr),
    .ic_rd_rdy    (ic_rd_rdy),
    .ic_ret_valid (ic_ret_valid),
    .dc_rd_req    (dc_rd_req),
    .dc_rd_type   (dc_rd_type),
    .dc_rd_addr   (dc_rd_addr),
    .dc_rd_rdy    (dc_rd_rdy),
    .dc_ret_valid (dc_ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_type  (mem_rd_type),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_rdy   (mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid),
    .mem_ret_last (mem_ret_last),
    .mem_ret_data (mem_ret_data),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory side of one granted transaction. Entered just after the grant was
  // checked (mid-cycle); returns at the negedge of the IDLE cycle that
  // follows the last beat, with the return bus idle.
  task automatic mem_phase(input bit dc, input logic [31:0] addr, input logic [2:0] typ,
                           input int stall, input int beats, input int last_at,
                           input bit hold);
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      if (!hold && s == 0) begin
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
      end
      mem_rd_rdy = (s == stall);
      #1;
      check("mem_rd_req", mem_rd_req, 1);
      check("mem_rd_addr", mem_rd_addr, addr);
      check("mem_rd_type", mem_rd_type, typ);
      check("ic_rd_rdy_busy", ic_rd_rdy, 0);
      check("dc_rd_rdy_busy", dc_rd_rdy, 0);
    end
    for (int b = 0; b < beats; b++) begin
      @(negedge clk);
      mem_rd_rdy    = 1'b0;
      mem_ret_valid = 1'b1;
      mem_ret_last  = (b == last_at);
      mem_ret_data  = addr + 32'(b * 4);
      #1;
      check("ic_ret_valid", ic_ret_valid, !dc);
      check("dc_ret_valid", dc_ret_valid, dc);
      check("ret_data", ret_data, addr + 32'(b * 4));
      check("ret_last", ret_last, (b == last_at));
      if (b == 0) check("mem_rd_req_drop", mem_rd_req, 0);
    end
    @(negedge clk);
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_ret_data  = 32'h0;
  endtask

  initial begin
    resetn        = 1'b0;
    ic_rd_req     = 1'b1;
    ic_rd_addr    = IC_A0;
    dc_rd_req     = 1'b0;
    dc_rd_type    = 3'b010;
    dc_rd_addr    = 32'h0;
    mem_rd_rdy    = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_ret_data  = 32'h0;

    // Reset state, with a request pending that must not be acknowledged.
    @(negedge clk); #1;
    check("rst_ic_rd_rdy", ic_rd_rdy, 0);
    check("rst_dc_rd_rdy", dc_rd_rdy, 0);
    check("rst_mem_rd_req", mem_rd_req, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_mem_rd_type", mem_rd_type, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_ic_ret_valid", ic_ret_valid, 0);
    check("rst_dc_ret_valid", dc_ret_valid, 0);

    // IC alone, granted in the first cycle after reset release; 16-beat line.
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("s1_ic_grant", ic_rd_rdy, 1);
    check("s1_dc_nogrant", dc_rd_rdy, 0);
    mem_phase(1'b0, IC_A0, 3'b100, 0, 16, 15, 1'b0);
    #1;
    check("s1_proto_err", proto_err, 0);

    // Reset, then continuous requests from both sides for 8 transactions.
    resetn = 1'b0;
    @(negedge clk);
    resetn     = 1'b1;
    ic_rd_req  = 1'b1;
    ic_rd_addr = IC_A1;
    dc_rd_req  = 1'b1;
    dc_rd_type = 3'b010;
    dc_rd_addr = DC_A0;
    #1;
    for (int t = 0; t < 8; t++) begin
      automatic bit exp_dc = ((t % 2) == 0);
      check("rr_ic_rdy", ic_rd_rdy, !exp_dc);
      check("rr_dc_rdy", dc_rd_rdy, exp_dc);
      mem_phase(exp_dc, exp_dc ? DC_A0 : IC_A1, exp_dc ? 3'b010 : 3'b100,
                0, exp_dc ? 1 : 16, exp_dc ? 0 : 15, (t != 7));
      #1;
    end
    check("rr_idle_ic_rdy", ic_rd_rdy, 0);
    check("rr_idle_dc_rdy", dc_rd_rdy, 0);
    check("rr_proto_err", proto_err, 0);

    // DC word read with the memory stalling for 5 cycles.
    @(negedge clk);
    dc_rd_req  = 1'b1;
    dc_rd_type = 3'b010;
    dc_rd_addr = DC_A1;
    #1;
    check("s4_dc_grant", dc_rd_rdy, 1);
    mem_phase(1'b1, DC_A1, 3'b010, 5, 1, 0, 1'b0);
    #1;
    check("s4_proto_err", proto_err, 0);

    // Line refill whose last flag arrives on beat 15 of 16.
    @(negedge clk);
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h1fc0_0080;
    #1;
    check("s5_ic_grant", ic_rd_rdy, 1);
    mem_phase(1'b0, 32'h1fc0_0080, 3'b100, 0, 15, 14, 1'b0);
    #1;
    check("s5_proto_err_set", proto_err, 1);
    // Back in IDLE: an immediate grant proves the FSM followed the last flag.
    dc_rd_req  = 1'b1;
    dc_rd_type = 3'b010;
    dc_rd_addr = 32'h8000_3000;
    #1;
    check("s5_idle_grant", dc_rd_rdy, 1);
    mem_phase(1'b1, 32'h8000_3000, 3'b010, 0, 1, 0, 1'b0);
    #1;
    check("s5_proto_err_sticky", proto_err, 1);

    // Reset clears the sticky error.
    resetn = 1'b0;
    #1;
    check("s6_rst_proto_err", proto_err, 0);
    @(negedge clk);
    resetn     = 1'b1;
    ic_rd_req  = 1'b1;
    ic_rd_addr = 32'h1fc0_0100;
    #1;
    check("s6_ic_grant", ic_rd_rdy, 1);
    @(negedge clk);
    ic_rd_req  = 1'b0;
    mem_rd_rdy = 1'b1;
    #1;
    check("s6_mem_rd_req", mem_rd_req, 1);
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      mem_rd_rdy    = 1'b0;
      mem_ret_valid = 1'b1;
      mem_ret_last  = 1'b0;
      mem_ret_data  = 32'h1fc0_0100 + 32'(b * 4);
      #1;
      check("s6_ic_ret_valid", ic_ret_valid, 1);
    end
    // Reset during beat 7 of the refill.
    #1;
    resetn    = 1'b0;
    ic_rd_req = 1'b1;
    #1;
    check("s6_mid_ic_ret_valid", ic_ret_valid, 0);
    check("s6_mid_dc_ret_valid", dc_ret_valid, 0);
    check("s6_mid_ic_rd_rdy", ic_rd_rdy, 0);
    check("s6_mid_dc_rd_rdy", dc_rd_rdy, 0);
    check("s6_mid_mem_rd_req", mem_rd_req, 0);
    check("s6_mid_mem_rd_addr", mem_rd_addr, 0);
    check("s6_mid_mem_rd_type", mem_rd_type, 0);
    check("s6_mid_ret_last", ret_last, 0);
    check("s6_mid_proto_err", proto_err, 0);
    @(negedge clk);
    mem_ret_valid = 1'b0;
    mem_ret_data  = 32'h0;
    resetn        = 1'b1;
    ic_rd_addr    = IC_A0;
    #1;
    check("s6_post_ic_grant", ic_rd_rdy, 1);
    mem_phase(1'b0, IC_A0, 3'b100, 0, 16, 15, 1'b0);
    #1;
    check("s6_post_proto_err", proto_err, 0);

    // Return beat while IDLE is not routed and flags a protocol error.
    @(negedge clk);
    mem_ret_valid = 1'b1;
    mem_ret_data  = 32'hdead_beef;
    #1;
    check("idle_beat_ic_ret_valid", ic_ret_valid, 0);
    check("idle_beat_dc_ret_valid", dc_ret_valid, 0);
    @(negedge clk);
    mem_ret_valid = 1'b0;
    #1;
    check("idle_beat_proto_err", proto_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cache_rd_arbiter
`default_nettype wire
